// File: rtl/aska_spi.sv
// rtl/aska_spi.sv - SPI mode-0 write-only slave holding four ASKA configuration registers
// Optional readback on SPI_MISO when ASKA_SPI_READBACK_EN is defined.
module aska_spi #(
  parameter int M      = 32,
  parameter int ADDR_W = 8
) (
  input  logic         SPI_Clk,
  input  logic         resetn,
  input  logic         SPI_CS,
  input  logic         SPI_MOSI,
`ifdef ASKA_SPI_READBACK_EN
  output logic         SPI_MISO,
`endif
  output logic [M-1:0] conf0,
  output logic [M-1:0] conf1,
  output logic [M-1:0] ele1,
  output logic [M-1:0] ele2
);

  localparam int FW = ADDR_W + M;
  localparam logic [5:0] LAST_BIT = 6'(FW - 1);

  logic [FW-2:0] shreg;
  logic [5:0]    cnt;
  logic [FW-1:0] word;
  logic          commit;

  assign word   = {shreg, SPI_MOSI};
  assign commit = !SPI_CS && (cnt == LAST_BIT);

  // Frame state is cleared asynchronously by CS so any non-zero CS high time separates frames.
  always_ff @(posedge SPI_Clk or negedge resetn or posedge SPI_CS) begin
    if (!resetn) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (SPI_CS) begin
      shreg <= '0;
      cnt   <= '0;
    end else begin
      shreg <= word[FW-2:0];
      if (cnt != 6'h3f) cnt <= cnt + 6'd1;
    end
  end

  always_ff @(posedge SPI_Clk or negedge resetn) begin
    if (!resetn) begin
      conf0 <= '0;
      conf1 <= '0;
      ele1  <= '0;
      ele2  <= '0;
    end else if (commit) begin
      case (word[FW-1 -: ADDR_W])
        ADDR_W'(0): conf0 <= word[M-1:0];
        ADDR_W'(1): conf1 <= word[M-1:0];
        ADDR_W'(2): ele1  <= word[M-1:0];
        ADDR_W'(3): ele2  <= word[M-1:0];
        default: ;
      endcase
    end
  end

`ifdef ASKA_SPI_READBACK_EN
  logic [ADDR_W-1:0] rd_addr;
  logic [M-1:0]      rd_word;
  logic [5:0]        rd_idx;

  // Address is complete on the edge delivering its last bit; hold it for the data phase.
  always_ff @(posedge SPI_Clk or negedge resetn or posedge SPI_CS) begin
    if (!resetn) begin
      rd_addr <= '0;
    end else if (SPI_CS) begin
      rd_addr <= '0;
    end else if (cnt == 6'(ADDR_W - 1)) begin
      rd_addr <= word[ADDR_W-1:0];
    end
  end

  always_comb begin
    rd_word = '0;
    case (rd_addr)
      ADDR_W'(0): rd_word = conf0;
      ADDR_W'(1): rd_word = conf1;
      ADDR_W'(2): rd_word = ele1;
      ADDR_W'(3): rd_word = ele2;
      default:    rd_word = '0;
    endcase
  end

  assign rd_idx = LAST_BIT - cnt;

  // Launched on the falling edge so the master samples it on the following rising edge.
  always_ff @(negedge SPI_Clk or negedge resetn or posedge SPI_CS) begin
    if (!resetn) begin
      SPI_MISO <= 1'b0;
    end else if (SPI_CS) begin
      SPI_MISO <= 1'b0;
    end else if (cnt >= 6'(ADDR_W) && cnt <= LAST_BIT) begin
      SPI_MISO <= rd_word[rd_idx[$clog2(M)-1:0]];
    end else begin
      SPI_MISO <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_aska_spi.sv
// tb/tb_aska_spi.sv - directed self-checking bench for aska_spi
// Readback checks are compiled in when ASKA_SPI_READBACK_EN is defined.
module tb_aska_spi;

  logic        SPI_Clk  = 1'b0;
  logic        resetn   = 1'b0;
  logic        SPI_CS   = 1'b1;
  logic        SPI_MOSI = 1'b0;
  logic [31:0] conf0, conf1, ele1, ele2;
  int          checks = 0;
  int          errors = 0;

`ifdef ASKA_SPI_READBACK_EN
  logic        SPI_MISO;
  logic [63:0] rx;
`endif

  aska_spi #(.M(32), .ADDR_W(8)) dut (
    .SPI_Clk  (SPI_Clk),
    .resetn   (resetn),
    .SPI_CS   (SPI_CS),
    .SPI_MOSI (SPI_MOSI),
`ifdef ASKA_SPI_READBACK_EN
    .SPI_MISO (SPI_MISO),
`endif
    .conf0    (conf0),
    .conf1    (conf1),
    .ele1     (ele1),
    .ele2     (ele2)
  );

  // Master drives MOSI while the clock is low and samples MISO just before the rising edge.
  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      SPI_MOSI = v[i];
      #5;
`ifdef ASKA_SPI_READBACK_EN
      rx = {rx[62:0], SPI_MISO};
`endif
      SPI_Clk = 1'b1;
      #5;
      SPI_Clk = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] addr, input logic [63:0] data, input int n);
`ifdef ASKA_SPI_READBACK_EN
    rx = '0;
`endif
    SPI_CS = 1'b0;
    #5;
    send_bits({56'h0, addr}, 8);
    send_bits(data, n);
    #5;
    SPI_CS = 1'b1;
    #5;
  endtask

  task automatic test_reset;
    SPI_CS = 1'b1;
    resetn = 1'b0;
    #10;
    resetn = 1'b1;
    #5;
    checks++; if (conf0 !== 32'h0) begin errors++; $display("FAIL reset_conf0 got %h exp %h", conf0, 32'h0); end
    checks++; if (conf1 !== 32'h0) begin errors++; $display("FAIL reset_conf1 got %h exp %h", conf1, 32'h0); end
    checks++; if (ele1 !== 32'h0) begin errors++; $display("FAIL reset_ele1 got %h exp %h", ele1, 32'h0); end
    checks++; if (ele2 !== 32'h0) begin errors++; $display("FAIL reset_ele2 got %h exp %h", ele2, 32'h0); end
`ifdef ASKA_SPI_READBACK_EN
    checks++; if (SPI_MISO !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", SPI_MISO); end
`endif
  endtask

  task automatic test_full_frame;
    SPI_CS = 1'b0;
    #5;
    send_bits({24'h0, 8'h00, 32'hAABBCCDD}, 40);
    #2;
    checks++; if (conf0 !== 32'hAABBCCDD) begin errors++; $display("FAIL full_conf0_cs_low got %h exp %h", conf0, 32'hAABBCCDD); end
    SPI_CS = 1'b1;
    #5;
    checks++; if (conf1 !== 32'h0) begin errors++; $display("FAIL full_conf1 got %h exp %h", conf1, 32'h0); end
    checks++; if (ele1 !== 32'h0) begin errors++; $display("FAIL full_ele1 got %h exp %h", ele1, 32'h0); end
    checks++; if (ele2 !== 32'h0) begin errors++; $display("FAIL full_ele2 got %h exp %h", ele2, 32'h0); end
  endtask

  task automatic test_truncated;
    frame(8'h03, 64'h554466, 24);
    checks++; if (ele2 !== 32'h0) begin errors++; $display("FAIL trunc_ele2 got %h exp %h", ele2, 32'h0); end
    frame(8'h03, 64'h0BADF00D, 32);
    checks++; if (ele2 !== 32'h0BADF00D) begin errors++; $display("FAIL trunc_next_ele2 got %h exp %h", ele2, 32'h0BADF00D); end
    checks++; if (conf0 !== 32'hAABBCCDD) begin errors++; $display("FAIL trunc_conf0 got %h exp %h", conf0, 32'hAABBCCDD); end
  endtask

  task automatic test_sequence;
    frame(8'h01, 64'h3377EEFF, 32);
    frame(8'h02, 64'hBEBECACA, 32);
    frame(8'h03, 64'hCAFEBABA, 32);
    checks++; if (conf0 !== 32'hAABBCCDD) begin errors++; $display("FAIL seq_conf0 got %h exp %h", conf0, 32'hAABBCCDD); end
    checks++; if (conf1 !== 32'h3377EEFF) begin errors++; $display("FAIL seq_conf1 got %h exp %h", conf1, 32'h3377EEFF); end
    checks++; if (ele1 !== 32'hBEBECACA) begin errors++; $display("FAIL seq_ele1 got %h exp %h", ele1, 32'hBEBECACA); end
    checks++; if (ele2 !== 32'hCAFEBABA) begin errors++; $display("FAIL seq_ele2 got %h exp %h", ele2, 32'hCAFEBABA); end
  endtask

  task automatic test_bad_addr_overlong;
    frame(8'h07, 64'h12345678, 32);
    checks++; if (conf0 !== 32'hAABBCCDD) begin errors++; $display("FAIL bad_conf0 got %h exp %h", conf0, 32'hAABBCCDD); end
    checks++; if (conf1 !== 32'h3377EEFF) begin errors++; $display("FAIL bad_conf1 got %h exp %h", conf1, 32'h3377EEFF); end
    checks++; if (ele1 !== 32'hBEBECACA) begin errors++; $display("FAIL bad_ele1 got %h exp %h", ele1, 32'hBEBECACA); end
    checks++; if (ele2 !== 32'hCAFEBABA) begin errors++; $display("FAIL bad_ele2 got %h exp %h", ele2, 32'hCAFEBABA); end
    frame(8'h00, {16'h0, 32'h5A5A1234, 16'hFFFF}, 48);
    checks++; if (conf0 !== 32'h5A5A1234) begin errors++; $display("FAIL long_conf0 got %h exp %h", conf0, 32'h5A5A1234); end
    checks++; if (conf1 !== 32'h3377EEFF) begin errors++; $display("FAIL long_conf1 got %h exp %h", conf1, 32'h3377EEFF); end
  endtask

`ifdef ASKA_SPI_READBACK_EN
  task automatic test_readback;
    frame(8'h02, 64'hBEBECACA, 32);
    checks++; if (rx[31:0] !== 32'hBEBECACA) begin errors++; $display("FAIL rb_data got %h exp %h", rx[31:0], 32'hBEBECACA); end
    checks++; if (rx[39:32] !== 8'h00) begin errors++; $display("FAIL rb_addr_phase got %h exp %h", rx[39:32], 8'h00); end
    checks++; if (SPI_MISO !== 1'b0) begin errors++; $display("FAIL rb_miso_cs_high got %b exp 0", SPI_MISO); end
    frame(8'h01, 64'h3377EEFF, 32);
    checks++; if (rx[31:0] !== 32'h3377EEFF) begin errors++; $display("FAIL rb_conf1 got %h exp %h", rx[31:0], 32'h3377EEFF); end
    frame(8'h09, 64'hFFFFFFFF, 32);
    checks++; if (rx[31:0] !== 32'h0) begin errors++; $display("FAIL rb_unknown got %h exp %h", rx[31:0], 32'h0); end
  endtask
`endif

  task automatic test_back_to_back;
    SPI_CS = 1'b0;
    #5;
    send_bits({24'h0, 8'h00, 32'h11112222}, 40);
    #5;
    SPI_CS = 1'b1;
    #1;
    SPI_CS = 1'b0;
    #4;
    send_bits({24'h0, 8'h01, 32'h33334444}, 40);
    #5;
    SPI_CS = 1'b1;
    #5;
    checks++; if (conf0 !== 32'h11112222) begin errors++; $display("FAIL b2b_conf0 got %h exp %h", conf0, 32'h11112222); end
    checks++; if (conf1 !== 32'h33334444) begin errors++; $display("FAIL b2b_conf1 got %h exp %h", conf1, 32'h33334444); end
  endtask

  task automatic test_reset_midframe;
    SPI_CS = 1'b0;
    #5;
    send_bits({44'h0, 8'h00, 12'hABC}, 20);
    #2;
    resetn = 1'b0;
    #2;
    checks++; if (conf0 !== 32'h0) begin errors++; $display("FAIL mid_conf0 got %h exp %h", conf0, 32'h0); end
    checks++; if (conf1 !== 32'h0) begin errors++; $display("FAIL mid_conf1 got %h exp %h", conf1, 32'h0); end
    checks++; if (ele1 !== 32'h0) begin errors++; $display("FAIL mid_ele1 got %h exp %h", ele1, 32'h0); end
    checks++; if (ele2 !== 32'h0) begin errors++; $display("FAIL mid_ele2 got %h exp %h", ele2, 32'h0); end
    resetn = 1'b1;
    SPI_CS = 1'b1;
    #5;
    frame(8'h03, 64'hCAFEBABA, 32);
    checks++; if (ele2 !== 32'hCAFEBABA) begin errors++; $display("FAIL post_reset_ele2 got %h exp %h", ele2, 32'hCAFEBABA); end
    checks++; if (conf0 !== 32'h0) begin errors++; $display("FAIL post_reset_conf0 got %h exp %h", conf0, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_truncated();
    test_sequence();
    test_bad_addr_overlong();
`ifdef ASKA_SPI_READBACK_EN
    test_readback();
`endif
    test_back_to_back();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
